// File: rtl/hall_decoder.sv
// ============================================================================
//  Module   : hall_decoder
//  Purpose  : Decodes deglitched U/V/W hall signals into a commutation sector
//             and tracks direction, signed step position and error flags.
//             Define HALL_DECODER_PERIOD_EN to add step-interval measurement.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hall_decoder #(
  parameter int POSITION_WIDTH = 16,
  parameter int PERIOD_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clk_en,
  input  logic                      hall_u,
  input  logic                      hall_v,
  input  logic                      hall_w,
  input  logic                      error_clear,
  output logic [2:0]                sector,
  output logic                      direction,
  output logic                      step,
  output logic [POSITION_WIDTH-1:0] position,
  output logic [PERIOD_WIDTH-1:0]   period,
  output logic                      period_valid,
  output logic                      invalid_error,
  output logic                      skip_error
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [2:0] C_NO_SECTOR = 3'd7;

  state_t                      r_state;
  logic [2:0]                  r_sector;
  logic                        r_direction;
  logic                        r_step;
  logic [POSITION_WIDTH-1:0]   r_position;
  logic                        r_invalid_error;
  logic                        r_skip_error;

  logic [2:0] w_code;
  logic [2:0] w_new;
  logic       w_legal;
  logic [3:0] w_sum;
  logic [3:0] w_diff;
  logic       w_tracking;
  logic       w_fwd;
  logic       w_rev;
  logic       w_skip;
  logic       w_illegal_trk;

  assign w_code = {hall_w, hall_v, hall_u};

  always_comb begin
    w_legal = 1'b1;
    w_new   = 3'd0;
    case (w_code)
      3'b001:  w_new = 3'd0;
      3'b011:  w_new = 3'd1;
      3'b010:  w_new = 3'd2;
      3'b110:  w_new = 3'd3;
      3'b100:  w_new = 3'd4;
      3'b101:  w_new = 3'd5;
      default: w_legal = 1'b0;
    endcase
  end

  // Sector difference modulo 6; r_sector is always 0..5 while tracking.
  assign w_sum         = {1'b0, w_new} + 4'd6 - {1'b0, r_sector};
  assign w_diff        = (w_sum >= 4'd6) ? (w_sum - 4'd6) : w_sum;
  assign w_tracking    = (r_state == ST_TRACK);
  assign w_fwd         = w_tracking & w_legal & (w_diff == 4'd1);
  assign w_rev         = w_tracking & w_legal & (w_diff == 4'd5);
  assign w_skip        = w_tracking & w_legal & (w_diff >= 4'd2) & (w_diff <= 4'd4);
  assign w_illegal_trk = w_tracking & ~w_legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_INIT;
      r_sector        <= C_NO_SECTOR;
      r_direction     <= 1'b1;
      r_step          <= 1'b0;
      r_position      <= '0;
      r_invalid_error <= 1'b0;
      r_skip_error    <= 1'b0;
    end else begin
      // A step pulse lasts one clk cycle regardless of the next clk_en.
      r_step <= 1'b0;
      if (clk_en) begin
        case (r_state)
          ST_INIT: begin
            if (w_legal) begin
              r_state  <= ST_TRACK;
              r_sector <= w_new;
            end
          end
          ST_TRACK: begin
            if (!w_legal) begin
              r_state  <= ST_INIT;
              r_sector <= C_NO_SECTOR;
            end else if (w_fwd) begin
              r_sector    <= w_new;
              r_position  <= r_position + POSITION_WIDTH'(1);
              r_direction <= 1'b1;
              r_step      <= 1'b1;
            end else if (w_rev) begin
              r_sector    <= w_new;
              r_position  <= r_position - POSITION_WIDTH'(1);
              r_direction <= 1'b0;
              r_step      <= 1'b1;
            end else if (w_skip) begin
              r_sector <= w_new;
            end
          end
          default: begin
            r_state  <= ST_INIT;
            r_sector <= C_NO_SECTOR;
          end
        endcase
        r_invalid_error <= (r_invalid_error & ~error_clear) | w_illegal_trk;
        r_skip_error    <= (r_skip_error & ~error_clear) | w_skip;
      end
    end
  end

  assign sector        = r_sector;
  assign direction     = r_direction;
  assign step          = r_step;
  assign position      = r_position;
  assign invalid_error = r_invalid_error;
  assign skip_error    = r_skip_error;

`ifdef HALL_DECODER_PERIOD_EN
  localparam logic [PERIOD_WIDTH-1:0] C_PERIOD_MAX = '1;

  logic [PERIOD_WIDTH-1:0] r_count;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic                    r_period_valid;
  logic                    r_have_prev;
  logic [PERIOD_WIDTH-1:0] w_count_inc;
  logic                    w_load;

  assign w_count_inc = (r_count == C_PERIOD_MAX) ? C_PERIOD_MAX : (r_count + PERIOD_WIDTH'(1));
  assign w_load      = ~w_tracking & w_legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count        <= '0;
      r_period       <= C_PERIOD_MAX;
      r_period_valid <= 1'b0;
      r_have_prev    <= 1'b0;
    end else if (clk_en) begin
      if (w_fwd | w_rev) begin
        r_count     <= '0;
        r_have_prev <= 1'b1;
        // Only an interval bounded by two same-direction steps is a speed sample.
        if (r_have_prev && (w_fwd == r_direction)) begin
          r_period       <= w_count_inc;
          r_period_valid <= 1'b1;
        end else begin
          r_period_valid <= 1'b0;
        end
      end else if (w_load | w_skip) begin
        r_count <= '0;
        if (w_skip) begin
          r_period_valid <= 1'b0;
        end
      end else begin
        r_count <= w_count_inc;
        if (w_illegal_trk) begin
          r_period_valid <= 1'b0;
        end
        if (r_count == C_PERIOD_MAX) begin
          r_period       <= C_PERIOD_MAX;
          r_period_valid <= 1'b0;
        end
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
`else
  assign period       = '1;
  assign period_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hall_decoder.sv
// ============================================================================
//  Module   : tb_hall_decoder
//  Purpose  : Self-checking bench for hall_decoder against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hall_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [2:0]  code = 3'b000;
  logic        error_clear = 1'b0;

  logic [2:0]  sector;
  logic        direction, step, period_valid, invalid_error, skip_error;
  logic [15:0] position, period;
  logic [2:0]  sector_b;
  logic        direction_b, step_b, period_valid_b, invalid_error_b, skip_error_b;
  logic [15:0] position_b;
  logic [3:0]  period_b;

  int n_checks = 0;
  int n_fail   = 0;
  int stepcnt  = 0;

  always #5 clk = ~clk;

  hall_decoder #(.POSITION_WIDTH(16), .PERIOD_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .hall_u(code[0]), .hall_v(code[1]), .hall_w(code[2]), .error_clear(error_clear),
    .sector(sector), .direction(direction), .step(step), .position(position),
    .period(period), .period_valid(period_valid),
    .invalid_error(invalid_error), .skip_error(skip_error));

  hall_decoder #(.POSITION_WIDTH(16), .PERIOD_WIDTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .hall_u(code[0]), .hall_v(code[1]), .hall_w(code[2]), .error_clear(error_clear),
    .sector(sector_b), .direction(direction_b), .step(step_b), .position(position_b),
    .period(period_b), .period_valid(period_valid_b),
    .invalid_error(invalid_error_b), .skip_error(skip_error_b));

  // Behavioural model: "no sector" (7) means waiting for a legal code.
  typedef struct packed {
    int          sector;
    logic        dir;
    logic        step;
    logic [15:0] pos;
    logic        inv;
    logic        skp;
    logic        have_prev;
    int          cnt_a;
    int          per_a;
    logic        pv_a;
    int          cnt_b;
    int          per_b;
    logic        pv_b;
  } mstate_t;

  mstate_t m;
  int dec_tab [8] = '{-1, 0, 2, 1, 4, 5, 3, -1};
  int enc_tab [6] = '{1, 3, 2, 6, 4, 5};

  function automatic mstate_t mreset();
    mstate_t r;
    r.sector = 7; r.dir = 1'b1; r.step = 1'b0; r.pos = '0;
    r.inv = 1'b0; r.skp = 1'b0; r.have_prev = 1'b0;
    r.cnt_a = 0; r.per_a = 65535; r.pv_a = 1'b0;
    r.cnt_b = 0; r.per_b = 15; r.pv_b = 1'b0;
    return r;
  endfunction

  function automatic int sat_inc(int v, int sat);
    return (v + 1 > sat) ? sat : v + 1;
  endfunction

  function automatic void pupd(input int sat, input bit stp, input bit same, input bit restart,
                               input bit kill, input int cnt_i, input int per_i, input logic pv_i,
                               output int cnt_o, output int per_o, output logic pv_o);
    cnt_o = cnt_i; per_o = per_i; pv_o = pv_i;
`ifdef HALL_DECODER_PERIOD_EN
    if (stp) begin
      if (same) begin per_o = sat_inc(cnt_i, sat); pv_o = 1'b1; end
      else pv_o = 1'b0;
      cnt_o = 0;
    end else if (restart) begin
      cnt_o = 0;
      if (kill) pv_o = 1'b0;
    end else begin
      if (kill) pv_o = 1'b0;
      if (cnt_i == sat) begin per_o = sat; pv_o = 1'b0; end
      cnt_o = sat_inc(cnt_i, sat);
    end
`else
    per_o = sat; pv_o = 1'b0; cnt_o = 0;
`endif
  endfunction

  function automatic mstate_t mnext(mstate_t s, logic [2:0] c, logic en, logic clr);
    mstate_t n = s;
    int nw, d;
    bit stp = 0, fwd = 0, ill = 0, skp = 0, restart = 0, same = 0;
    int co, po;
    logic vo;
    n.step = 1'b0;
    if (!en) return n;
    nw = dec_tab[c];
    if (s.sector == 7) begin
      if (nw >= 0) begin n.sector = nw; restart = 1; end
    end else if (nw < 0) begin
      n.sector = 7; ill = 1;
    end else begin
      d = (nw - s.sector + 6) % 6;
      if (d == 1 || d == 5) begin
        stp = 1; fwd = (d == 1);
        n.sector = nw; n.step = 1'b1; n.dir = fwd;
        n.pos = fwd ? s.pos + 16'd1 : s.pos - 16'd1;
      end else if (d != 0) begin
        skp = 1; restart = 1; n.sector = nw;
      end
    end
    same = s.have_prev && (fwd == bit'(s.dir));
    if (stp) n.have_prev = 1'b1;
    n.inv = (s.inv && !clr) || ill;
    n.skp = (s.skp && !clr) || skp;
    pupd(65535, stp, same, restart, skp || ill, s.cnt_a, s.per_a, s.pv_a, co, po, vo);
    n.cnt_a = co; n.per_a = po; n.pv_a = vo;
    pupd(15, stp, same, restart, skp || ill, s.cnt_b, s.per_b, s.pv_b, co, po, vo);
    n.cnt_b = co; n.per_b = po; n.pv_b = vo;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= mreset();
    else          m <= mnext(m, code, clk_en, error_clear);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("sector", 64'(sector), 64'(m.sector));
    chk("direction", 64'(direction), 64'(m.dir));
    chk("step", 64'(step), 64'(m.step));
    chk("position", 64'(position), 64'(m.pos));
    chk("invalid_error", 64'(invalid_error), 64'(m.inv));
    chk("skip_error", 64'(skip_error), 64'(m.skp));
    chk("period", 64'(period), 64'(m.per_a));
    chk("period_valid", 64'(period_valid), 64'(m.pv_a));
    chk("period_w4", 64'(period_b), 64'(m.per_b));
    chk("period_valid_w4", 64'(period_valid_b), 64'(m.pv_b));
    if (step) stepcnt <= stepcnt + 1;
  end

  task automatic apply(input logic [2:0] c, input int n);
    code = c; clk_en = 1'b1;
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [15:0] p0;
  int          s0, cur;
  int          r;

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    chk("rst_sector", 64'(sector), 64'd7);
    chk("rst_position", 64'(position), 64'd0);
    chk("rst_period", 64'(period), 64'hFFFF);
    chk("rst_direction", 64'(direction), 64'd1);

    apply(3'b001, 3);
    chk("init_sector", 64'(sector), 64'd0);
    chk("init_position", 64'(position), 64'd0);
    chk("init_nostep", 64'(stepcnt), 64'd0);

    apply(3'b001, 10);
    foreach (enc_tab[i]) if (i > 0) apply(3'(enc_tab[i]), 10);
    apply(3'b001, 10);
    chk("fwd_steps", 64'(stepcnt), 64'd6);
    chk("fwd_position", 64'(position), 64'd6);
    chk("fwd_direction", 64'(direction), 64'd1);
    chk("fwd_sector", 64'(sector), 64'd0);
`ifdef HALL_DECODER_PERIOD_EN
    chk("fwd_period", 64'(period), 64'd10);
    chk("fwd_period_valid", 64'(period_valid), 64'd1);
`else
    chk("fwd_period", 64'(period), 64'hFFFF);
    chk("fwd_period_valid", 64'(period_valid), 64'd0);
`endif

    apply(3'b011, 10);
    apply(3'b010, 10);
    p0 = position;
    apply(3'b011, 10);
    chk("rev1_position", 64'(position), 64'(16'(p0 - 16'd1)));
    chk("rev1_direction", 64'(direction), 64'd0);
    chk("rev1_period_valid", 64'(period_valid), 64'd0);
    apply(3'b001, 10);
    chk("rev2_position", 64'(position), 64'(16'(p0 - 16'd2)));

    p0 = position;
    apply(3'b110, 5);
    chk("skip_flag", 64'(skip_error), 64'd1);
    chk("skip_sector", 64'(sector), 64'd3);
    chk("skip_position", 64'(position), 64'(p0));
    error_clear = 1'b1;
    apply(3'b110, 1);
    error_clear = 1'b0;
    chk("skip_cleared", 64'(skip_error), 64'd0);

    s0 = stepcnt;
    apply(3'b111, 3);
    chk("inv_flag", 64'(invalid_error), 64'd1);
    chk("inv_sector", 64'(sector), 64'd7);
    apply(3'b010, 3);
    chk("reload_sector", 64'(sector), 64'd2);
    chk("reload_nostep", 64'(stepcnt), 64'(s0));
    chk("reload_position", 64'(position), 64'(p0));

    apply(3'b010, 20);
    chk("stall_period_w4", 64'(period_b), 64'd15);
    chk("stall_valid_w4", 64'(period_valid_b), 64'd0);

    cur = 2;
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       code = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
      else if (r < 12) begin cur = $urandom_range(0, 5); code = 3'(enc_tab[cur]); end
      else begin
        cur = (cur + $urandom_range(0, 2) + 5) % 6;
        code = 3'(enc_tab[cur]);
      end
      clk_en = ($urandom_range(0, 3) != 0);
      error_clear = ($urandom_range(0, 19) == 0);
      if (k == 800) begin
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_sector", 64'(sector), 64'd7);
        chk("arst_position", 64'(position), 64'd0);
        chk("arst_step", 64'(step), 64'd0);
        chk("arst_direction", 64'(direction), 64'd1);
        chk("arst_errors", 64'({invalid_error, skip_error}), 64'd0);
        chk("arst_period", 64'({period, period_valid}), 64'({16'hFFFF, 1'b0}));
        @(posedge clk);
        #2 reset_n = 1'b1;
      end else begin
        @(posedge clk);
        #2;
      end
    end
    clk_en = 1'b0;
    error_clear = 1'b0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
